verinject_injection_scheduler: RTL and testbench

Sequencing controller for the memory fault-injection fabric. It holds a small table of (cycle, bit-index) injection entries loaded through a valid/ready port. After `start`, it counts run cycles and drives the shared 32-bit `verinject__injector_state` bus with one bit index per scheduled cycle. Between injections it drives the idle code `32'hFFFF_FFFF`, and on request it drives the FIFO-reset code `32'hFFFF_FFFE`. It sits at the top of the injection hierarchy and feeds every memory and register injector instance.

---
 rtl/verinject_injection_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_verinject_injection_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/verinject_injection_scheduler.sv
// Injection scheduler: replays a table of (cycle, bit-index) entries onto the shared
// injector bus during a run, with idle and FIFO-reset codes between injections.
module verinject_injection_scheduler #(
  parameter int DEPTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_cycle,
  input  logic [31:0] load_index,
  input  logic        flush,
  input  logic        start,
  input  logic        clear_req,
  output logic        busy,
  output logic        done,
  output logic        late,
  output logic [31:0] cycle_count,
  output logic [31:0] verinject__injector_state
);

  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

  localparam logic [31:0]         IDLE_CODE  = 32'hFFFF_FFFF;
  localparam logic [31:0]         RESET_CODE = 32'hFFFF_FFFE;
  localparam logic [DEPTH_LOG2:0] FULL       = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PTR_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] PTR_ZERO   = '0;

  state_t state_reg, state_next;

  logic [DEPTH_LOG2:0] count_reg, count_next;
  logic [DEPTH_LOG2:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2:0] rd_ptr_reg, rd_ptr_next;
  logic [31:0]         cycle_count_reg, cycle_count_next;
  logic [31:0]         bus_reg, bus_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                late_reg, late_next;

  logic [31:0] cycle_mem [DEPTH];
  logic [31:0] index_mem [DEPTH];

  logic [31:0] head_cycle;
  logic [31:0] head_index;
  logic        run_end;
  logic        fire;
  logic        load_accept;

  assign head_cycle  = cycle_mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
  assign head_index  = index_mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
  assign run_end     = (rd_ptr_reg == count_reg);
  assign fire        = !run_end && (head_cycle <= cycle_count_reg);
  assign load_ready  = (state_reg == IDLE) && (count_reg < FULL);
  // Higher-priority controls in the same cycle suppress the write.
  assign load_accept = load_valid && load_ready && !clear_req && !flush && !start;

  always_ff @(posedge clock) begin
    if (load_accept) begin
      cycle_mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= load_cycle;
      index_mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= load_index;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
        end else if (!flush && start && (count_reg != PTR_ZERO)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (clear_req) begin
          state_next = CLEAR;
        end else if (run_end) begin
          state_next = IDLE;
        end
      end
      CLEAR: begin
        if (!clear_req) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next       = count_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    cycle_count_next = cycle_count_reg;
    bus_next         = IDLE_CODE;
    busy_next        = busy_reg;
    done_next        = 1'b0;
    late_next        = late_reg;
    if (clear_req) begin
      bus_next    = RESET_CODE;
      busy_next   = 1'b0;
      rd_ptr_next = PTR_ZERO;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (flush) begin
            count_next  = PTR_ZERO;
            wr_ptr_next = PTR_ZERO;
            rd_ptr_next = PTR_ZERO;
            late_next   = 1'b0;
          end else if (start) begin
            late_next = 1'b0;
            if (count_reg != PTR_ZERO) begin
              busy_next        = 1'b1;
              cycle_count_next = '0;
              rd_ptr_next      = PTR_ZERO;
            end else begin
              done_next = 1'b1;
            end
          end else if (load_accept) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
            count_next  = count_reg + PTR_ONE;
          end
        end
        RUN: begin
          if (cycle_count_reg != 32'hFFFF_FFFF) begin
            cycle_count_next = cycle_count_reg + 32'd1;
          end
          if (run_end) begin
            busy_next = 1'b0;
            done_next = 1'b1;
          end else if (fire) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
            // Entries carrying a reserved code are consumed silently.
            if (head_index < RESET_CODE) begin
              bus_next = head_index;
            end
            if (head_cycle < cycle_count_reg) begin
              late_next = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg       <= PTR_ZERO;
      wr_ptr_reg      <= PTR_ZERO;
      rd_ptr_reg      <= PTR_ZERO;
      cycle_count_reg <= '0;
      bus_reg         <= IDLE_CODE;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      late_reg        <= 1'b0;
    end else begin
      count_reg       <= count_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      cycle_count_reg <= cycle_count_next;
      bus_reg         <= bus_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      late_reg        <= late_next;
    end
  end

  assign busy                     = busy_reg;
  assign done                     = done_reg;
  assign late                     = late_reg;
  assign cycle_count              = cycle_count_reg;
  assign verinject__injector_state = bus_reg;

endmodule

// File: tb/tb_verinject_injection_scheduler.sv
// Bench for verinject_injection_scheduler: table-driven schedules checked through an
// injection scoreboard, plus hand-written full-table, clear and reset sequences.
module tb_verinject_injection_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_cycle;
  logic [31:0] load_index;
  logic        flush;
  logic        start;
  logic        clear_req;
  logic        busy;
  logic        done;
  logic        late;
  logic [31:0] cycle_count;
  logic [31:0] bus;

  always #5 clock = ~clock;

  verinject_injection_scheduler #(.DEPTH(8), .DEPTH_LOG2(3)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .load_valid               (load_valid),
    .load_ready               (load_ready),
    .load_cycle               (load_cycle),
    .load_index               (load_index),
    .flush                    (flush),
    .start                    (start),
    .clear_req                (clear_req),
    .busy                     (busy),
    .done                     (done),
    .late                     (late),
    .cycle_count              (cycle_count),
    .verinject__injector_state(bus)
  );

  typedef struct {
    int          scen;
    logic [31:0] cyc;
    logic [31:0] idx;
    logic [31:0] exp_cc;
    logic        exp_late;
  } vec_t;

  typedef struct {
    logic [31:0] idx;
    logic [31:0] cc;
    logic        late;
  } exp_t;

  vec_t vecs [7];
  exp_t sbq [$];
  exp_t mon_e;

  int  n_cmp    = 0;
  int  n_fail   = 0;
  int  done_cnt = 0;
  int  fffe_cnt = 0;
  bit  mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every non-idle bus value must match the oldest expected injection.
  always @(negedge clock) begin
    if (mon_en) begin
      if (done === 1'b1) done_cnt++;
      if (bus === 32'hFFFF_FFFE) begin
        fffe_cnt++;
      end else if (bus !== 32'hFFFF_FFFF) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_inject: got %h expected none", bus);
        end else begin
          mon_e = sbq.pop_front();
          chk("inject_idx", bus, mon_e.idx);
          chk("inject_cc", cycle_count, mon_e.cc);
          chk("inject_late", {31'b0, late}, {31'b0, mon_e.late});
          $display("inject idx=%h cc=%0d late=%0b", bus, cycle_count, late);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic flush_table();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("ready_after_flush", {31'b0, load_ready}, 32'd1);
  endtask

  task automatic load(input logic [31:0] c, input logic [31:0] i);
    load_valid = 1'b1;
    load_cycle = c;
    load_index = i;
    step();
    load_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] cc, input logic lt);
    exp_t e;
    e.idx  = i;
    e.cc   = cc;
    e.late = lt;
    sbq.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("cc_after_start", cycle_count, 32'd0);
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int s, input logic [31:0] exp_cc);
    int t;
    bit got;
    t   = 0;
    got = 1'b0;
    while (!got && t < 400) begin
      @(negedge clock);
      if (done === 1'b1) got = 1'b1;
      else t++;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout_s%0d: got no done expected done within 400 cycles", s);
    end else begin
      chk($sformatf("done_cc_s%0d", s), cycle_count, exp_cc);
      chk($sformatf("done_busy_s%0d", s), {31'b0, busy}, 32'd0);
    end
    @(posedge clock);
    #1;
    chk($sformatf("done_pulse_s%0d", s), {31'b0, done}, 32'd0);
    $display("run s%0d finished cc=%0d late=%0b", s, cycle_count, late);
  endtask

  int          scen_ids [3];
  logic [31:0] scen_done_cc [3];
  logic        scen_late [3];

  initial begin
    int f0;
    int d0;
    int t;

    vecs[0] = '{1, 32'd5, 32'd100, 32'd6, 1'b0};
    vecs[1] = '{1, 32'd9, 32'd7, 32'd10, 1'b0};
    vecs[2] = '{2, 32'd3, 32'd1, 32'd4, 1'b0};
    vecs[3] = '{2, 32'd3, 32'd2, 32'd5, 1'b1};
    vecs[4] = '{2, 32'd3, 32'd3, 32'd6, 1'b1};
    vecs[5] = '{5, 32'd2, 32'hFFFF_FFFE, 32'd0, 1'b0};
    vecs[6] = '{5, 32'd4, 32'd12, 32'd5, 1'b0};
    scen_ids     = '{1, 2, 5};
    scen_done_cc = '{32'd11, 32'd7, 32'd6};
    scen_late    = '{1'b0, 1'b1, 1'b0};

    reset      = 1'b1;
    load_valid = 1'b0;
    load_cycle = '0;
    load_index = '0;
    flush      = 1'b0;
    start      = 1'b0;
    clear_req  = 1'b0;
    repeat (3) step();
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("rst_bus", bus, 32'hFFFF_FFFF);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_late", {31'b0, late}, 32'd0);
    chk("rst_cc", cycle_count, 32'd0);
    chk("rst_ready", {31'b0, load_ready}, 32'd1);

    // Table-driven schedules.
    for (int k = 0; k < 3; k++) begin
      flush_table();
      for (int v = 0; v < 7; v++) begin
        if (vecs[v].scen == scen_ids[k]) begin
          load(vecs[v].cyc, vecs[v].idx);
          if (vecs[v].idx < 32'hFFFF_FFFE) push(vecs[v].idx, vecs[v].exp_cc, vecs[v].exp_late);
        end
      end
      f0 = fffe_cnt;
      do_start();
      wait_done(scen_ids[k], scen_done_cc[k]);
      chk($sformatf("queue_empty_s%0d", scen_ids[k]), sbq.size(), 32'd0);
      chk($sformatf("late_s%0d", scen_ids[k]), {31'b0, late}, {31'b0, scen_late[k]});
      chk($sformatf("no_reset_code_s%0d", scen_ids[k]), fffe_cnt - f0, 32'd0);
    end

    // Full table, rejected ninth offer, then replay of the same schedule.
    flush_table();
    for (int i = 0; i < 8; i++) begin
      load(32'(2 * i), 32'(200 + i));
      push(32'(200 + i), 32'(2 * i + 1), 1'b0);
    end
    chk("ready_full", {31'b0, load_ready}, 32'd0);
    load(32'd1, 32'd77);
    chk("ready_full_after_offer", {31'b0, load_ready}, 32'd0);
    do_start();
    wait_done(3, 32'd16);
    chk("queue_empty_s3a", sbq.size(), 32'd0);
    for (int i = 0; i < 8; i++) push(32'(200 + i), 32'(2 * i + 1), 1'b0);
    do_start();
    wait_done(3, 32'd16);
    chk("queue_empty_s3b", sbq.size(), 32'd0);

    // Abort a run with clear_req.
    flush_table();
    load(32'd20, 32'd55);
    f0 = fffe_cnt;
    d0 = done_cnt;
    do_start();
    t = 0;
    while (cycle_count !== 32'd10 && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk("clear_reached_cc10", cycle_count, 32'd10);
    clear_req = 1'b1;
    @(posedge clock);
    #1;
    clear_req = 1'b0;
    chk("clear_bus", bus, 32'hFFFF_FFFE);
    chk("clear_busy", {31'b0, busy}, 32'd0);
    chk("clear_cc_hold", cycle_count, 32'd10);
    step();
    chk("clear_bus_idle", bus, 32'hFFFF_FFFF);
    chk("clear_ready", {31'b0, load_ready}, 32'd1);
    repeat (30) step();
    chk("clear_no_done", done_cnt - d0, 32'd0);
    chk("clear_one_code", fffe_cnt - f0, 32'd1);
    chk("clear_queue_empty", sbq.size(), 32'd0);

    // Reset in the middle of a run, then start on the emptied table.
    flush_table();
    load(32'd50, 32'd9);
    do_start();
    repeat (5) step();
    chk("run_ready_low", {31'b0, load_ready}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_bus", bus, 32'hFFFF_FFFF);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_late", {31'b0, late}, 32'd0);
    chk("mid_rst_cc", cycle_count, 32'd0);
    chk("mid_rst_ready", {31'b0, load_ready}, 32'd1);
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("empty_start_done", {31'b0, done}, 32'd1);
    chk("empty_start_busy", {31'b0, busy}, 32'd0);
    step();
    chk("empty_start_done_low", {31'b0, done}, 32'd0);
    repeat (60) step();
    chk("empty_start_one_done", done_cnt - d0, 32'd1);
    chk("empty_start_queue", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
